// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Purpose  : Shared sizes and FSM encodings for the ALU operand arbiter.
// Revision : 1.0
// ============================================================================
package alu_arb_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_XFER = 1'b1
   } arb_state_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/mux16_1.sv
`default_nettype none
// ============================================================================
// Module   : mux16_1
// Purpose  : 16:1 operand multiplexer feeding the ALU datapath.
// Revision : 1.0
// ============================================================================
module mux16_1
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] d [N_REQ],
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] y
);

   assign y = d[sel];

endmodule : mux16_1
`default_nettype wire

// File: rtl/mux16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_arbiter
// Purpose  : Round-robin arbiter/sequencer driving mux16_1 select and a
//            valid/ready output. Optional burst mode: define ARB_BURST_EN.
// Revision : 1.0
// ============================================================================
module mux16_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] data_flat,
   output logic [N_REQ-1:0]       grant,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       out_sel
);

   // First requester at or after last+1, wrapping; i = N_REQ revisits last.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] pick;
      logic             found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = last + SEL_W'(i);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_burst_len_check
      $error("mux16_arbiter: BURST_LEN must be in 1..16");
   end

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [SEL_W-1:0] r_last_sel;
   logic [SEL_W-1:0] w_last_nxt;
   logic [SEL_W-1:0] w_win;
   logic [N_REQ-1:0] w_grant;
   logic             w_accept;
   logic [WIDTH-1:0] w_mux_y;
   logic [WIDTH-1:0] w_slices [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slices[gi] = data_flat[gi*WIDTH +: WIDTH];
   end

   mux16_1 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .d   (w_slices),
      .sel (r_sel),
      .y   (w_mux_y)
   );

`ifdef ARB_BURST_EN
   localparam logic [SEL_W-1:0] c_burst_max = SEL_W'(BURST_LEN - 1);

   // r_beat_cnt counts accepted repeat beats, so the round-robin beat plus
   // c_burst_max repeats make a full burst without overflowing 4 bits.
   logic [SEL_W-1:0] r_beat_cnt;
   logic             r_rep;
   logic             r_have_last;
   logic             w_repeat;

   assign w_repeat = r_have_last && req[r_last_sel] && (r_beat_cnt < c_burst_max);
   assign w_win    = w_repeat ? r_last_sel : rr_pick(req, r_last_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt  <= '0;
         r_rep       <= 1'b0;
         r_have_last <= 1'b0;
      end else if (r_state == ARB_IDLE && |req) begin
         if (w_repeat) begin
            r_rep <= 1'b1;
         end else begin
            r_rep      <= 1'b0;
            r_beat_cnt <= '0;
         end
      end else if (w_accept) begin
         r_have_last <= 1'b1;
         if (r_rep) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end
`else
   assign w_win = rr_pick(req, r_last_sel);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_last_nxt  = r_last_sel;
      w_grant     = '0;
      w_accept    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|req) begin
               w_sel_nxt   = w_win;
               w_state_nxt = ARB_XFER;
            end
         end
         ARB_XFER: begin
            if (out_ready) begin
               w_accept         = 1'b1;
               w_grant[r_sel]   = 1'b1;
               w_last_nxt       = r_sel;
               w_state_nxt      = ARB_IDLE;
            end else if (!req[r_sel]) begin
               // Withdrawn before accept: drop the beat, keep fairness pointer.
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_sel      <= '0;
         r_last_sel <= {SEL_W{1'b1}};
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_last_sel <= w_last_nxt;
      end
   end

   assign out_valid = (r_state == ARB_XFER);
   assign out_data  = out_valid ? w_mux_y : '0;
   assign out_sel   = r_sel;
   assign grant     = w_grant;

endmodule : mux16_arbiter
`default_nettype wire

// File: tb/tb_mux16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_arbiter
// Purpose  : Directed vector table plus hand-written sequences for the arbiter.
// Revision : 1.0
// ============================================================================
module tb_mux16_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  req = '0;
   logic [255:0] data_flat;
   logic [15:0]  grant;
   logic         out_valid;
   logic         rdy = 1'b0;
   logic [15:0]  out_data;
   logic [3:0]   out_sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] req;
      logic        rdy;
      logic        exp_valid;
      logic [3:0]  exp_sel;
      logic [15:0] exp_data;
      logic [15:0] exp_grant;
   } vec_t;

   vec_t vecs [22];

   mux16_arbiter #(
      .WIDTH     (16),
      .BURST_LEN (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_flat (data_flat),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (rdy),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [15:0] r, input logic rd,
                          input logic v, input logic [3:0] s,
                          input logic [15:0] d, input logic [15:0] g);
      vecs[i] = '{r, rd, v, s, d, g};
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; req = '0; rdy = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   int n;
   int last_cyc;
   int e;
   int exp_order [9];

   initial begin
      for (int i = 0; i < 16; i++) data_flat[i*16 +: 16] = 16'(i);

      set_vec( 0, 16'hFFFF, 1, 0, 0, 16'h0, 16'h0);
      set_vec( 1, 16'hFFFF, 0, 1, 0, 16'h0, 16'h0);
      set_vec( 2, 16'hFFFF, 1, 1, 0, 16'h0, 16'h0001);
      set_vec( 3, 16'h0000, 0, 0, 0, 16'h0, 16'h0);
      set_vec( 4, 16'h0020, 1, 0, 0, 16'h0, 16'h0);
      set_vec( 5, 16'h0020, 1, 1, 5, 16'h5, 16'h0020);
      set_vec( 6, 16'h0000, 1, 0, 5, 16'h0, 16'h0);
      set_vec( 7, 16'h0000, 1, 0, 5, 16'h0, 16'h0);
      set_vec( 8, 16'h0008, 0, 0, 5, 16'h0, 16'h0);
      for (int i = 9; i <= 13; i++) set_vec(i, 16'h0008, 0, 1, 3, 16'h3, 16'h0);
      set_vec(14, 16'h0008, 1, 1, 3, 16'h3, 16'h0008);
      set_vec(15, 16'h0000, 1, 0, 3, 16'h0, 16'h0);
      set_vec(16, 16'h0200, 0, 0, 3, 16'h0, 16'h0);
      set_vec(17, 16'h0200, 0, 1, 9, 16'h9, 16'h0);
      set_vec(18, 16'h0000, 0, 1, 9, 16'h9, 16'h0);
      set_vec(19, 16'hFFFF, 0, 0, 9, 16'h0, 16'h0);
`ifdef ARB_BURST_EN
      set_vec(20, 16'hFFFF, 1, 1, 3, 16'h3, 16'h0008);
      set_vec(21, 16'h0000, 1, 0, 3, 16'h0, 16'h0);
`else
      set_vec(20, 16'hFFFF, 1, 1, 4, 16'h4, 16'h0010);
      set_vec(21, 16'h0000, 1, 0, 4, 16'h0, 16'h0);
`endif

      // Reset held with random requests and ready high.
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req = 16'($urandom);
      end
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_sel", 32'(out_sel), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; req = '0; rdy = 1'b0;

      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         req = vecs[i].req;
         rdy = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
         check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      end

      // Fairness: all requesting, ready held high.
      do_reset();
      req = 16'hFFFF; rdy = 1'b1;
      n = 0; last_cyc = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (grant != 16'h0 && n < 17) begin
`ifdef ARB_BURST_EN
            e = (n / 4) % 16;
`else
            e = n % 16;
`endif
            check($sformatf("fair%0d_grant", n), 32'(grant), 32'(16'h1 << e));
            check($sformatf("fair%0d_data", n), 32'(out_data), 32'(e));
            if (n > 0) check($sformatf("fair%0d_gap", n), 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            n++;
         end
      end
      check("fair_count", 32'(n), 32'd17);

      // Burst: requesters 2 and 7 held.
`ifdef ARB_BURST_EN
      exp_order = '{2, 2, 2, 2, 7, 7, 7, 7, 2};
`else
      exp_order = '{2, 7, 2, 7, 2, 7, 2, 7, 2};
`endif
      do_reset();
      req = 16'h0084; rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (grant != 16'h0 && n < 9) begin
            check($sformatf("burst%0d_grant", n), 32'(grant), 32'(16'h1 << exp_order[n]));
            n++;
         end
      end
      check("burst_count", 32'(n), 32'd9);

      // Asynchronous reset in the middle of a transfer.
      do_reset();
      req = 16'h0008; rdy = 1'b0;
      @(posedge clk); #2;
      check("midrst_pre_valid", 32'(out_valid), 32'h1);
      rdy = 1'b1;
      #1;
      check("midrst_pre_grant", 32'(grant), 32'h0008);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_grant", 32'(grant), 32'h0);
      check("midrst_data", 32'(out_data), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; req = '0; rdy = 1'b0;
      @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux16_arbiter
`default_nettype wire
